// File: rtl/instr_mem_loader_if.sv
// instr_mem_loader_if -- command, byte-stream and memory-write bundle for instr_mem_loader.
//
// Parameters:
//   ADDR_W     width of the instruction-memory word address
// Signals:
//   start      begin a load (sampled by the loader only while idle)
//   num_words  number of 16-bit words to load, sampled with start (ADDR_W+1 bits)
//   rx_data    incoming program byte
//   rx_valid   rx_data is valid
//   rx_ready   loader accepts a byte this cycle
//   mem_we     instruction-memory write strobe
//   mem_addr   word address being written
//   mem_wdata  instruction word being written
//   busy       loader is not idle
//   done       one-cycle pulse at the end of a load
//   error      checksum mismatch flag
// Modports:
//   master     the side that commands the load and supplies bytes
//   slave      the loader itself
interface instr_mem_loader_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W:0]   num_words;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, num_words, rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, busy, done, error
    );

    modport slave (
        input  start, num_words, rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, busy, done, error
    );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader -- assembles a byte stream into big-endian 16-bit instruction
// words and writes them to consecutive instruction-memory addresses.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    instr_mem_loader_if.slave (start/num_words command, rx byte stream,
//          memory write port, busy/done/error status)
//
// Build option:
//   LOADER_CHECKSUM_EN  when defined, one extra byte is consumed after the last
//                       word and compared with the XOR of all data bytes; a
//                       mismatch raises error until the next accepted start.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// HI    | waiting for the high byte of the current word
// LO    | waiting for the low byte of the current word
// WRITE | one-cycle memory write of {hi, lo}
// CHK   | waiting for the checksum byte (LOADER_CHECKSUM_EN only)
// DONE  | one-cycle done pulse
module instr_mem_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic                clk,
    input logic                reset,
    instr_mem_loader_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HI    = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd5;
`endif

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic [2:0]        state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   wr_cnt_nxt;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              xfer;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
    logic              err_q;

    assign bus.rx_ready = (state == S_HI) || (state == S_LO) || (state == S_CHK);
    assign bus.error    = err_q;
`else
    assign bus.rx_ready = (state == S_HI) || (state == S_LO);
    assign bus.error    = 1'b0;
`endif

    assign xfer          = bus.rx_valid && bus.rx_ready;
    assign wr_cnt_nxt    = wr_cnt + 1'b1;
    assign bus.mem_we    = (state == S_WRITE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= '0;
            wr_cnt  <= '0;
            hi_byte <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        wr_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum   <= '0;
                        err_q  <= 1'b0;
`endif
                        if (bus.num_words == '0) begin
                            state <= S_DONE;
                        end else begin
                            // Oversized requests are clamped so the address never wraps.
                            count <= (bus.num_words > DEPTH_W) ? DEPTH_W : bus.num_words;
                            state <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        hi_byte <= bus.rx_data;
`ifdef LOADER_CHECKSUM_EN
                        csum    <= csum ^ bus.rx_data;
`endif
                        state   <= S_LO;
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        // Address/data registers only move here, so they hold the
                        // last written word outside WRITE.
                        addr_q  <= wr_cnt[ADDR_W-1:0];
                        wdata_q <= {hi_byte, bus.rx_data};
`ifdef LOADER_CHECKSUM_EN
                        csum    <= csum ^ bus.rx_data;
`endif
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wr_cnt <= wr_cnt_nxt;
                    if (wr_cnt_nxt == count) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= S_CHK;
`else
                        state <= S_DONE;
`endif
                    end else begin
                        state <= S_HI;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        err_q <= (bus.rx_data != csum);
                        state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampn(input int nw);
        return (nw > DEPTH) ? DEPTH : nw;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    bit          m_busy = 0, m_pend_we = 0, m_pend_done = 0, m_have_hi = 0, m_in_chk = 0;
    logic        m_err = 1'b0;
    int          m_n = 0, m_idx = 0;
    logic [7:0]  m_hi = '0, m_csum = '0;
    logic [3:0]  m_addr = '0;
    logic [15:0] m_data = '0;

    int          cyc = 0;
    int          last_wr_cyc = 0, done_cyc = 0, done_count = 0;
    logic [19:0] wlog[$];

    always @(negedge clk) begin : compare
        bit         e_we, e_done, e_rdy;
        logic [4:0] nw;
        cyc++;
        e_we   = m_pend_we;
        e_done = m_pend_done;
        e_rdy  = m_busy && !e_we && !e_done;
        chk("mem_we",    bus.mem_we,    e_we);
        chk("done",      bus.done,      e_done);
        chk("busy",      bus.busy,      m_busy);
        chk("rx_ready",  bus.rx_ready,  e_rdy);
        chk("mem_addr",  bus.mem_addr,  m_addr);
        chk("mem_wdata", bus.mem_wdata, m_data);
        chk("error",     bus.error,     m_err);
        if (bus.mem_we === 1'b1) begin
            wlog.push_back({bus.mem_addr, bus.mem_wdata});
            last_wr_cyc = cyc;
        end
        if (bus.done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
        m_pend_we   = 0;
        m_pend_done = 0;
        if (reset) begin
            m_busy = 0; m_have_hi = 0; m_in_chk = 0;
            m_err = 1'b0; m_addr = '0; m_data = '0; m_csum = '0;
        end else if (e_done) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (bus.start) begin
                nw = bus.num_words;
                m_n = clampn(int'(nw));
                m_err = 1'b0; m_csum = '0; m_idx = 0; m_have_hi = 0; m_in_chk = 0;
                m_busy = 1;
                if (m_n == 0) m_pend_done = 1;
            end
        end else if (e_we) begin
            if (m_idx == m_n) begin
                if (CK) m_in_chk = 1;
                else    m_pend_done = 1;
            end
        end else if (bus.rx_valid) begin
            if (m_in_chk) begin
                m_err = (bus.rx_data != m_csum);
                m_pend_done = 1;
            end else begin
                m_csum = m_csum ^ bus.rx_data;
                if (!m_have_hi) begin
                    m_hi = bus.rx_data;
                    m_have_hi = 1;
                end else begin
                    m_have_hi = 0;
                    m_pend_we = 1;
                    m_addr = m_idx[3:0];
                    m_data = {m_hi, bus.rx_data};
                    m_idx++;
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic [7:0] bq[$];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // mode 0: back-to-back, 1: one idle cycle before every byte, 2: random gaps
    task automatic send_byte(input logic [7:0] b, input int mode);
        bit acc;
        int gaps;
        gaps = (mode == 1) ? 1 : (mode == 2) ? $urandom_range(3) : 0;
        repeat (gaps) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            tick();
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            acc = bus.rx_ready;
            tick();
            if (acc) break;
        end
        if (!acc) chk("rx_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_load(input int nw);
        bus.start     = 1'b1;
        bus.num_words = nw[4:0];
        tick();
        bus.start     = 1'b0;
        bus.num_words = 5'($urandom);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                idle = 1;
                break;
            end
        end
        if (!idle) chk("idle_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic fill(input int nbytes);
        bq.delete();
        repeat (nbytes) bq.push_back(8'($urandom));
    endtask

    // Runs one load of the bytes in bq and checks the resulting write sequence.
    task automatic run_load(input int nw, input int mode, input bit bad_ck);
        int         n;
        logic [7:0] cs;
        n  = clampn(nw);
        cs = '0;
        wlog.delete();
        start_load(nw);
        for (int i = 0; i < 2 * n; i++) begin
            cs = cs ^ bq[i];
            send_byte(bq[i], mode);
        end
`ifdef LOADER_CHECKSUM_EN
        if (n > 0) send_byte(bad_ck ? (cs ^ 8'h01) : cs, mode);
`else
        if (bad_ck) cs = ~cs;
`endif
        bus.rx_valid = 1'b0;
        wait_idle();
        chk("load_write_count", wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size(); i++)
            chk("load_word", wlog[i], {i[3:0], bq[2*i], bq[2*i+1]});
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0, dc;
        reset = 1'b1;
        bus.start = 1'b0; bus.num_words = '0; bus.rx_valid = 1'b0; bus.rx_data = '0;
        repeat (3) tick();
        chk("rst_busy",      bus.busy,      32'd0);
        chk("rst_rx_ready",  bus.rx_ready,  32'd0);
        chk("rst_mem_we",    bus.mem_we,    32'd0);
        chk("rst_mem_addr",  bus.mem_addr,  32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_done",      bus.done,      32'd0);
        chk("rst_error",     bus.error,     32'd0);
        reset = 1'b0;
        tick();

        // two words back-to-back
        bq = {8'h12, 8'h34, 8'h56, 8'h78};
        run_load(2, 0, 1'b0);
        chk("t2w_word0", wlog[0], 32'h0_1234);
        chk("t2w_word1", wlog[1], 32'h1_5678);
`ifndef LOADER_CHECKSUM_EN
        chk("t2w_done_after_write", done_cyc - last_wr_cyc, 32'd1);
`endif

        // full depth with rx_valid toggling
        fill(32);
        run_load(16, 1, 1'b0);
        chk("tfull_count", wlog.size(), 32'd16);
        chk("tfull_last_addr", wlog[15][19:16], 32'd15);
        n0 = 0;
        foreach (wlog[i]) if (wlog[i][19:16] == 4'd0) n0++;
        chk("tfull_addr0_writes", n0, 32'd1);
        chk("tfull_busy_after", bus.busy, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        bq = {8'hAB, 8'hCD};
        run_load(1, 0, 1'b0);
        chk("tck_word", wlog[0], 32'h0_ABCD);
        chk("tck_good_error", bus.error, 32'd0);
        run_load(1, 0, 1'b1);
        repeat (5) tick();
        chk("tck_bad_error_held", bus.error, 32'd1);
        bq.delete();
        run_load(0, 0, 1'b0);
        chk("tck_error_cleared", bus.error, 32'd0);
`endif

        // reset after the high byte
        wlog.delete();
        start_load(1);
        send_byte(8'h9A, 0);
        bus.rx_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("trst_no_write", wlog.size(), 32'd0);
        chk("trst_busy", bus.busy, 32'd0);
        bq = {8'h00, 8'h01};
        run_load(1, 0, 1'b0);
        chk("trst_new_word", wlog[0], 32'h0_0001);

        // start pulsed mid-load is ignored
        fill(6);
        wlog.delete();
        start_load(3);
        send_byte(bq[0], 0);
        send_byte(bq[1], 0);
        bus.rx_valid = 1'b0;
        bus.start = 1'b1; bus.num_words = 5'd1;
        tick();
        bus.start = 1'b0;
        for (int i = 2; i < 6; i++) send_byte(bq[i], 2);
`ifdef LOADER_CHECKSUM_EN
        send_byte(bq[0] ^ bq[1] ^ bq[2] ^ bq[3] ^ bq[4] ^ bq[5], 0);
`endif
        bus.rx_valid = 1'b0;
        wait_idle();
        chk("tmid_write_count", wlog.size(), 32'd3);

        // zero words: done pulse, no write
        dc = done_count;
        bq.delete();
        run_load(0, 0, 1'b0);
        chk("tzero_no_write", wlog.size(), 32'd0);
        chk("tzero_done_pulses", done_count - dc, 32'd1);

        // clamping
        fill(32);
        run_load(20, 2, 1'b0);
        chk("tclamp_count", wlog.size(), 32'd16);
        fill(32);
        run_load(31, 0, 1'b0);

        // random loads
        for (int r = 0; r < 14; r++) begin
            int nw;
            nw = $urandom_range(0, 20);
            fill(2 * clampn(nw));
            run_load(nw, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, 16, number of 16-bit instruction words loadable (word addresses 0..DEPTH-1).
REQ-002 SHALL have parameter ADDR_W, 4, width of the word address driven to instruction memory.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: start  input  1  begin load; sampled only in IDLE.
REQ-007 Port: num_words  input  ADDR_W+1  words to load; sampled with start.
REQ-008 Port: rx_data  input  8  incoming program byte.
REQ-009 Port: rx_valid  input  1  rx_data valid.
REQ-010 Port: rx_ready  output  1  loader accepts byte this cycle.
REQ-011 Port: mem_we  output  1  instruction-memory write strobe.
REQ-012 Port: mem_addr  output  ADDR_W  word address written.
REQ-013 Port: mem_wdata  output  16  instruction word written.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: done  output  1  one-cycle pulse at end of load.
REQ-016 Port: error  output  1  checksum mismatch flag.

Function
REQ-017 States SHALL be IDLE, HI, LO, WRITE, CHK (only with REQ-032), DONE.
REQ-018 Byte transfer SHALL occur only on a cycle with rx_valid=1 and rx_ready=1; rx_ready SHALL be 1 only in HI, LO, CHK.
REQ-019 IDLE: start=1 with num_words in 1..DEPTH -> latch count, clear address to 0 -> HI; num_words=0 -> DONE with no writes; num_words>DEPTH -> clamp to DEPTH.
REQ-020 HI: on transfer, latch byte as bits 15:8 -> LO; LO: on transfer, latch byte as bits 7:0 -> WRITE (big-endian per word).
REQ-021 WRITE: mem_we=1 for exactly one cycle, mem_addr=current address, mem_wdata={hi,lo}; mem_we SHALL be 0 in all other states.
REQ-022 Latency: mem_we SHALL assert the cycle after the low byte is accepted; peak rate one word per 3 cycles.
REQ-023 After WRITE, address SHALL increment by 1; if words written equals latched count -> CHK (macro on) or DONE, else -> HI.
REQ-024 Address SHALL never wrap: at most DEPTH writes per load, last address DEPTH-1.
REQ-025 DONE: done=1 for one cycle -> IDLE.
REQ-026 start while busy=1 SHALL be ignored; num_words changes after start SHALL have no effect.
REQ-027 rx_valid low in HI/LO/CHK SHALL stall the state indefinitely with outputs held.
REQ-028 mem_addr and mem_wdata SHALL hold last written values outside WRITE.

Reset
REQ-029 reset=1 SHALL force IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, checksum=0.
REQ-030 Reset mid-load SHALL discard any partial word; words already written are not rewritten or cleared.
REQ-031 Reset SHALL take priority over start and rx_valid in the same cycle.

Configuration
REQ-032 With LOADER_CHECKSUM_EN defined: running XOR of all accepted data bytes cleared on start; CHK accepts one byte, error=1 if byte != XOR else 0 -> DONE; error held until next accepted start or reset.
REQ-033 Without LOADER_CHECKSUM_EN: no CHK state, no checksum byte consumed, error tied 0.

Verification
REQ-034 Reset, start, num_words=2, bytes 12 34 56 78 back-to-back -> writes addr0=0x1234, addr1=0x5678, done pulse 1 cycle after second write (macro off).
REQ-035 num_words=16, 32 bytes with rx_valid toggling every other cycle -> 16 writes addr 0..15, no write to addr 0 after 15, busy low after done.
REQ-036 Macro on, num_words=1, bytes AB CD then 66 -> write 0xABCD, error=0; repeat with checksum 67 -> error=1 held until next start.
REQ-037 Reset asserted after high byte 0x9A accepted -> IDLE, no mem_we, new start with 1 word 00 01 writes 0x0001 at addr 0.
REQ-038 start pulsed during load and num_words=0 start from IDLE -> mid-load start ignored; zero-word start gives done pulse with mem_we never asserted.
